// File: rtl/digit_projection_pkg.sv
// rtl/digit_projection_pkg.sv - shared types, constants and helpers for digit_projection
package digit_projection_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 4;

  // Monoc value treated as digit ink unless overridden by the instantiating block
  localparam logic FG_LEVEL_DEFAULT = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_WAIT,
    ST_ACCUM,
    ST_SCAN,
    ST_DONE
  } state_t;

  // One step of the segment tracker: open writes the low border, keep writes the high one
  typedef struct packed {
    logic   seg_open;
    logic   keep;
    coord_t hi;
  } seg_evt_t;

  // Border k occupies RAM words 2k (low edge) and 2k+1 (high edge)
  function automatic coord_t lo_addr(input logic [CNT_W-1:0] k);
    return {{(COORD_W-CNT_W-1){1'b0}}, k, 1'b0};
  endfunction

  function automatic coord_t hi_addr(input logic [CNT_W-1:0] k);
    return {{(COORD_W-CNT_W-1){1'b0}}, k, 1'b1};
  endfunction

endpackage

// File: rtl/digit_projection_if.sv
// rtl/digit_projection_if.sv - video input, border read ports and status of digit_projection
interface digit_projection_if;
  import digit_projection_pkg::*;

  logic             frame_vsync;
  logic             pixel_de;
  logic             monoc;
  coord_t           xpos;
  coord_t           ypos;
  coord_t           row_border_addr;
  coord_t           row_border_data;
  coord_t           col_border_addr;
  coord_t           col_border_data;
  logic [CNT_W-1:0] num_row;
  logic [CNT_W-1:0] num_col;
  logic [1:0]       frame_cnt;
  logic             project_done_flag;

  modport master (
    output frame_vsync, pixel_de, monoc, xpos, ypos, row_border_addr, col_border_addr,
    input  row_border_data, col_border_data, num_row, num_col, frame_cnt, project_done_flag
  );

  modport slave (
    input  frame_vsync, pixel_de, monoc, xpos, ypos, row_border_addr, col_border_addr,
    output row_border_data, col_border_data, num_row, num_col, frame_cnt, project_done_flag
  );

endinterface

// File: rtl/digit_projection_border_ram.sv
// rtl/digit_projection_border_ram.sv - border storage, one write port and one registered read port
module digit_projection_border_ram
  import digit_projection_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  coord_t           waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  coord_t           raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array write; words past the live count are don't-care so the array is not reset
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < coord_t'(DEPTH))) mem_q[waddr_i[IW-1:0]] <= wdata_i;
  end

  // Registered read, addresses outside the array return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rdata_q <= '0;
    else if (raddr_i < coord_t'(DEPTH)) rdata_q <= mem_q[raddr_i[IW-1:0]];
    else                                rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/digit_projection.sv
// rtl/digit_projection.sv - X/Y projection of a binarized frame into digit border RAMs
module digit_projection
  import digit_projection_pkg::*;
#(
  parameter int   H_PIXEL  = 640,
  parameter int   V_PIXEL  = 480,
  parameter int   MAX_COL  = 8,
  parameter int   MAX_ROW  = 4,
  parameter int   MIN_SPAN = 4,    // must be >= 2: a kept segment never opens and closes in one step
  parameter logic FG_LEVEL = FG_LEVEL_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  digit_projection_if.slave  bus
);

  localparam int     AW       = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
  localparam coord_t H_COUNT  = coord_t'(H_PIXEL);
  localparam coord_t H_LAST   = coord_t'(H_PIXEL - 1);
  localparam coord_t V_LAST   = coord_t'(V_PIXEL - 1);
  localparam coord_t SCAN_END = coord_t'(H_PIXEL + 1);

  state_t           state_q, state_d;
  logic             vs_q, de_q, line_fg_q, in_seg_q, done_q, vs_pend_q, rd_vld_q, rd_bit_q;
  coord_t           ypos_q, seg_start_q, clr_q, scan_cnt_q, rd_pos_q;
  logic [CNT_W-1:0] num_row_q, num_col_q;
  logic [1:0]       frame_cnt_q;
  logic             bitmap_q [H_PIXEL];

  logic             vs_rise, de_fall, pixel_fg, scan_rd;
  logic             clr_en, accum_en, scan_en, scan_exit, start_frame;
  logic             trk_valid, trk_bit, trk_last, trk_we;
  coord_t           trk_pos, trk_waddr, trk_wdata, row_rdata, col_rdata;
  logic [CNT_W-1:0] trk_cnt, trk_max;
  seg_evt_t         ev;

  // Open/close/span rule shared by the row path (per line) and the column path (per bitmap bit)
  function automatic seg_evt_t seg_step(input logic valid, input logic bit_v, input logic last,
                                        input logic in_seg, input logic room,
                                        input coord_t pos, input coord_t start);
    seg_evt_t e;
    coord_t   lo;
    logic     closing;
    e       = '0;
    lo      = '0;
    closing = 1'b0;
    if (valid) begin
      e.seg_open = bit_v & ~in_seg & room;
      if (bit_v && last) begin
        closing = 1'b1;
        lo      = in_seg ? start : pos;
        e.hi    = pos;
      end else if (!bit_v && in_seg) begin
        closing = 1'b1;
        lo      = start;
        e.hi    = pos - coord_t'(1);
      end
      e.keep = closing & room & ((e.hi - lo) >= coord_t'(MIN_SPAN - 1));
    end
    return e;
  endfunction

  assign vs_rise  = bus.frame_vsync & ~vs_q;
  assign de_fall  = de_q & ~bus.pixel_de;
  assign pixel_fg = bus.pixel_de && (bus.monoc == FG_LEVEL) && (bus.xpos < H_COUNT);
  assign scan_rd  = scan_en && (scan_cnt_q < H_COUNT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // FSM next-state: clear bitmap, wait for a frame, measure, scan, then hold for two frames
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_q == H_LAST)                       state_d = ST_WAIT;
      ST_WAIT:  if (vs_rise)                               state_d = ST_ACCUM;
      ST_ACCUM: if (de_fall && (ypos_q == V_LAST))         state_d = ST_SCAN;
      ST_SCAN:  if (scan_cnt_q == SCAN_END)                state_d = ST_DONE;
      ST_DONE:  if (vs_rise && (frame_cnt_q == 2'd2))      state_d = ST_ACCUM;
      default:                                             state_d = ST_CLEAR;
    endcase
  end

  // FSM outputs: per-state enables and the frame-start strobe
  always_comb begin
    clr_en      = 1'b0;
    accum_en    = 1'b0;
    scan_en     = 1'b0;
    scan_exit   = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      ST_CLEAR: clr_en = 1'b1;
      ST_WAIT:  start_frame = vs_rise;
      ST_ACCUM: accum_en = 1'b1;
      ST_SCAN: begin
        scan_en   = 1'b1;
        scan_exit = (scan_cnt_q == SCAN_END);
      end
      ST_DONE:  start_frame = vs_rise && (frame_cnt_q == 2'd2);
      default: ;
    endcase
  end

  // Feed the shared tracker from the line path while measuring, from the bitmap while scanning
  always_comb begin
    if (accum_en) begin
      trk_valid = de_fall;
      trk_bit   = line_fg_q;
      trk_pos   = ypos_q;
      trk_last  = (ypos_q == V_LAST);
      trk_cnt   = num_row_q;
      trk_max   = CNT_W'(MAX_ROW);
    end else begin
      trk_valid = scan_en & rd_vld_q;
      trk_bit   = rd_bit_q;
      trk_pos   = rd_pos_q;
      trk_last  = (rd_pos_q == H_LAST);
      trk_cnt   = num_col_q;
      trk_max   = CNT_W'(MAX_COL);
    end
  end

  assign ev        = seg_step(trk_valid, trk_bit, trk_last, in_seg_q, trk_cnt < trk_max,
                              trk_pos, seg_start_q);
  assign trk_we    = ev.seg_open | ev.keep;
  assign trk_waddr = ev.seg_open ? lo_addr(trk_cnt) : hi_addr(trk_cnt);
  assign trk_wdata = ev.seg_open ? trk_pos : ev.hi;

  // Column-occupancy bitmap: swept to zero after reset, set by ink, cleared as the scan reads it
  always_ff @(posedge clk) begin
    if (clr_en)                  bitmap_q[clr_q[AW-1:0]]      <= 1'b0;
    else if (accum_en && pixel_fg) bitmap_q[bus.xpos[AW-1:0]] <= 1'b1;
    else if (scan_rd)            bitmap_q[scan_cnt_q[AW-1:0]] <= 1'b0;
  end

  // Datapath: edge detect, line capture, scan pipeline, counts, frame phase and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;  de_q <= 1'b0;  line_fg_q <= 1'b0;  in_seg_q <= 1'b0;
      done_q <= 1'b0;  vs_pend_q <= 1'b0;  rd_vld_q <= 1'b0;  rd_bit_q <= 1'b0;
      ypos_q <= '0;  seg_start_q <= '0;  clr_q <= '0;  scan_cnt_q <= '0;  rd_pos_q <= '0;
      num_row_q <= '0;  num_col_q <= '0;  frame_cnt_q <= '0;
    end else begin
      vs_q       <= bus.frame_vsync;
      de_q       <= bus.pixel_de;
      if (bus.pixel_de) ypos_q <= bus.ypos;
      if (start_frame || de_fall)    line_fg_q <= 1'b0;
      else if (accum_en && pixel_fg) line_fg_q <= 1'b1;
      clr_q      <= clr_en  ? clr_q + coord_t'(1)      : '0;
      scan_cnt_q <= scan_en ? scan_cnt_q + coord_t'(1) : '0;
      rd_vld_q   <= scan_rd;
      rd_bit_q   <= scan_rd ? bitmap_q[scan_cnt_q[AW-1:0]] : 1'b0;
      rd_pos_q   <= scan_cnt_q;
      if (start_frame) begin
        in_seg_q <= 1'b0;
      end else if (trk_valid) begin
        in_seg_q <= trk_bit & ~trk_last;
        if (trk_bit && !in_seg_q) seg_start_q <= trk_pos;
      end
      if (start_frame) begin
        num_row_q <= '0;
        num_col_q <= '0;
      end else if (ev.keep) begin
        if (accum_en) num_row_q <= num_row_q + CNT_W'(1);
        else          num_col_q <= num_col_q + CNT_W'(1);
      end
      if (start_frame) begin
        frame_cnt_q <= 2'd0;
        done_q      <= 1'b0;
        vs_pend_q   <= 1'b0;
      end else if (scan_exit) begin
        done_q      <= 1'b1;
        frame_cnt_q <= (vs_pend_q | vs_rise) ? 2'd1 : 2'd0;
        vs_pend_q   <= 1'b0;
      end else if (scan_en && vs_rise) begin
        vs_pend_q   <= 1'b1;
      end else if ((state_q == ST_DONE) && vs_rise) begin
        frame_cnt_q <= frame_cnt_q + 2'd1;
      end
    end
  end

  digit_projection_border_ram #(.DEPTH(2 * MAX_ROW)) u_row_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (trk_we & accum_en),
    .waddr_i (trk_waddr),
    .wdata_i (trk_wdata),
    .raddr_i (bus.row_border_addr),
    .rdata_o (row_rdata)
  );

  digit_projection_border_ram #(.DEPTH(2 * MAX_COL)) u_col_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (trk_we & scan_en),
    .waddr_i (trk_waddr),
    .wdata_i (trk_wdata),
    .raddr_i (bus.col_border_addr),
    .rdata_o (col_rdata)
  );

  assign bus.row_border_data   = row_rdata;
  assign bus.col_border_data   = col_rdata;
  assign bus.num_row           = num_row_q;
  assign bus.num_col           = num_col_q;
  assign bus.frame_cnt         = frame_cnt_q;
  assign bus.project_done_flag = done_q;

endmodule
